// File: rtl/event_readout_rr_mux.sv
// Round-robin merge of NUM_CH event-readout FIFOs into one reader stream.
// One channel is served per block; it has an enable mask, a stall timeout and an exported channel index.
module event_readout_rr_mux #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned TW     = 2,
  parameter int unsigned NW_W   = 16,
  parameter int unsigned TO_W   = 16,
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_CH-1:0]      ch_enable_i,
  input  logic [NUM_CH-1:0]      ch_empty_i,
  input  logic [NUM_CH*DW-1:0]   ch_dat_i,
  input  logic [NUM_CH*TW-1:0]   ch_type_i,
  input  logic [NUM_CH*NW_W-1:0] ch_nwords_i,
  input  logic [NUM_CH-1:0]      ch_rst_req_i,
  output logic [NUM_CH-1:0]      ch_rd_o,
  output logic [NUM_CH-1:0]      ch_rst_ack_o,
  input  logic                   mx_rd_i,
  input  logic                   mx_block_done_i,
  input  logic                   mx_rst_ack_i,
  output logic                   mx_empty_o,
  output logic [DW-1:0]          mx_dat_o,
  output logic [TW-1:0]          mx_type_o,
  output logic [NW_W-1:0]        mx_nwords_o,
  output logic                   mx_rst_req_o,
  output logic                   mx_ack_o,
  output logic [CH_W-1:0]        mx_sel_o,
  input  logic [TO_W-1:0]        timeout_limit_i,
  output logic                   timeout_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACK = 2'd1, SELECT = 2'd2} state_t;

  state_t          state;
  logic [CH_W-1:0] ptr;
  logic [CH_W-1:0] sel;
  logic            hold;
  logic [TO_W-1:0] cnt;
  logic            ack;

  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] c);
    return (32'(c) + 32'd1 >= NUM_CH) ? '0 : c + CH_W'(1);
  endfunction

  // First enabled, non-empty channel at or after ptr (modulo NUM_CH).
  logic            found;
  logic [CH_W-1:0] pick;
  logic [CH_W-1:0] idx;
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      idx = CH_W'((int'(ptr) + i) % int'(NUM_CH));
      if (!found && ch_enable_i[idx] && !ch_empty_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  // Stall detection counts the current cycle, so the pulse lands in the L-th stalled cycle.
  logic [TO_W:0] cnt_inc;
  logic          to_hit;
  assign cnt_inc = {1'b0, cnt} + (TO_W+1)'(1);
  assign to_hit  = (state == SELECT) && !mx_block_done_i && !hold && !mx_rd_i &&
                   (timeout_limit_i != '0) && (cnt_inc == {1'b0, timeout_limit_i});

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      ptr   <= '0;
      sel   <= '0;
      hold  <= 1'b0;
      cnt   <= '0;
      ack   <= 1'b0;
    end else if (mx_rst_ack_i) begin
      state <= IDLE;
      ptr   <= '0;
      hold  <= 1'b0;
      cnt   <= '0;
      ack   <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (mx_block_done_i && state != ACK) hold <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            sel   <= pick;
            ack   <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          hold  <= 1'b0;
          cnt   <= '0;
          state <= SELECT;
        end
        SELECT: begin
          if (mx_block_done_i || hold || to_hit) begin
            ptr   <= next_ch(sel);
            state <= IDLE;
          end else if (mx_rd_i) begin
            cnt <= '0;
          end else if (cnt != '1) begin
            cnt <= cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Data path follows sel at all times; empty and read strobes only while serving.
  always_comb begin
    ch_rd_o = '0;
    if (state == SELECT) ch_rd_o[sel] = mx_rd_i;
  end

  assign mx_empty_o   = (state == SELECT) ? ch_empty_i[sel] : 1'b1;
  assign mx_dat_o     = ch_dat_i[32'(sel) * DW +: DW];
  assign mx_type_o    = ch_type_i[32'(sel) * TW +: TW];
  assign mx_nwords_o  = ch_nwords_i[32'(sel) * NW_W +: NW_W];
  assign mx_sel_o     = sel;
  assign mx_ack_o     = ack;
  assign timeout_o    = to_hit;
  assign mx_rst_req_o = |(ch_rst_req_i & ch_enable_i);
  assign ch_rst_ack_o = {NUM_CH{mx_rst_ack_i}};

endmodule

// File: tb/tb_event_readout_rr_mux.sv
// Bench for event_readout_rr_mux: directed corner cases, then randomized blocks
// checked against a queue-based round-robin model by a decoupled monitor.
module tb_event_readout_rr_mux;
  localparam int NCH = 4;
  localparam int DW = 16, TW = 2, NW_W = 16, TO_W = 16, CH_W = 2, D = 64;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [NCH-1:0]       ch_enable_i;
  logic [NCH-1:0]       ch_empty_i;
  logic [NCH*DW-1:0]    ch_dat_i;
  logic [NCH*TW-1:0]    ch_type_i;
  logic [NCH*NW_W-1:0]  ch_nwords_i;
  logic [NCH-1:0]       ch_rst_req_i;
  logic [NCH-1:0]       ch_rd_o;
  logic [NCH-1:0]       ch_rst_ack_o;
  logic                 mx_rd_i, mx_block_done_i, mx_rst_ack_i;
  logic                 mx_empty_o, mx_rst_req_o, mx_ack_o, timeout_o;
  logic [DW-1:0]        mx_dat_o;
  logic [TW-1:0]        mx_type_o;
  logic [NW_W-1:0]      mx_nwords_o;
  logic [CH_W-1:0]      mx_sel_o;
  logic [TO_W-1:0]      timeout_limit_i;

  always #5 clk_i = ~clk_i;

  event_readout_rr_mux #(.NUM_CH(NCH), .DW(DW), .TW(TW), .NW_W(NW_W), .TO_W(TO_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ch_enable_i(ch_enable_i), .ch_empty_i(ch_empty_i),
    .ch_dat_i(ch_dat_i), .ch_type_i(ch_type_i), .ch_nwords_i(ch_nwords_i),
    .ch_rst_req_i(ch_rst_req_i), .ch_rd_o(ch_rd_o), .ch_rst_ack_o(ch_rst_ack_o),
    .mx_rd_i(mx_rd_i), .mx_block_done_i(mx_block_done_i), .mx_rst_ack_i(mx_rst_ack_i),
    .mx_empty_o(mx_empty_o), .mx_dat_o(mx_dat_o), .mx_type_o(mx_type_o),
    .mx_nwords_o(mx_nwords_o), .mx_rst_req_o(mx_rst_req_o), .mx_ack_o(mx_ack_o),
    .mx_sel_o(mx_sel_o), .timeout_limit_i(timeout_limit_i), .timeout_o(timeout_o)
  );

  // Daughter FIFOs: contents written by the stimulus, popped by the DUT's read strobes.
  logic [DW-1:0] mem_d [NCH][D];
  logic [TW-1:0] mem_t [NCH][D];
  int            wp [NCH];
  int            rp [NCH];
  logic          clr;

  always @(posedge clk_i)
    for (int c = 0; c < NCH; c++)
      if (clr) rp[c] <= 0;
      else if (ch_rd_o[c] && rp[c] != wp[c]) rp[c] <= rp[c] + 1;

  always_comb
    for (int c = 0; c < NCH; c++) begin
      ch_empty_i[c]                  = clr || (rp[c] == wp[c]);
      ch_dat_i[c*DW +: DW]           = mem_d[c][6'(rp[c])];
      ch_type_i[c*TW +: TW]          = mem_t[c][6'(rp[c])];
      ch_nwords_i[c*NW_W +: NW_W]    = NW_W'(wp[c] - rp[c]);
    end

  typedef struct {
    bit              grant;
    logic [CH_W-1:0] ch;
    logic [DW-1:0]   d;
    logic [TW-1:0]   t;
    int              nw;
  } exp_t;

  exp_t exp_q[$];
  int   blk_q[$];
  bit   mon_en = 1'b0;
  int   n_pass = 0, n_tot = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(negedge clk_i);
    #1;
  endtask

  task automatic load(input int c, input int n);
    for (int i = 0; i < n; i++) begin
      mem_d[c][6'(wp[c])] = DW'($urandom);
      mem_t[c][6'(wp[c])] = TW'($urandom);
      wp[c]++;
    end
  endtask

  task automatic flush();
    step();
    clr = 1'b1; mx_rst_ack_i = 1'b1; mx_rd_i = 1'b0; mx_block_done_i = 1'b0;
    for (int c = 0; c < NCH; c++) wp[c] = 0;
    step();
    clr = 1'b0; mx_rst_ack_i = 1'b0;
  endtask

  task automatic wait_ack(input string name, input int ch);
    bit ok = 1'b0;
    for (int w = 0; w < 20 && !ok; w++) begin
      step();
      ok = mx_ack_o;
    end
    chk({name, "_ack"}, 64'(ok), 64'(1));
    chk({name, "_sel"}, 64'(mx_sel_o), 64'(ch));
  endtask

  task automatic release_block();
    mx_block_done_i = 1'b1;
    step();
    mx_block_done_i = 1'b0;
  endtask

  // Monitor: every grant and every merged read pops the next expected event.
  exp_t e;
  always begin
    @(negedge clk_i);
    #2;
    if (mon_en) begin
      if (mx_ack_o) begin
        if (exp_q.size() != 0 && exp_q[0].grant) begin
          e = exp_q.pop_front();
          chk("grant_ch", 64'(mx_sel_o), 64'(e.ch));
        end else chk("grant_unexpected", 64'(mx_ack_o), 64'(0));
      end
      if (mx_rd_i && !mx_empty_o) begin
        if (exp_q.size() != 0 && !exp_q[0].grant) begin
          e = exp_q.pop_front();
          chk("read_word", 64'({mx_sel_o, mx_dat_o, mx_type_o, mx_nwords_o}),
              64'({e.ch, e.d, e.t, NW_W'(e.nw)}));
          chk("read_strobe", 64'(ch_rd_o), 64'(4'(1) << e.ch));
        end else chk("read_unexpected", 64'(mx_rd_i && !mx_empty_o), 64'(0));
      end else if (ch_rd_o != '0) chk("read_leak", 64'(ch_rd_o), 64'(0));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   ptr_m, nblk, blk, got, c, c_sel;
    int   mr [NCH];
    bit   ok, bad;
    exp_t x;

    rst_i = 1'b1; clr = 1'b1; ch_enable_i = '0; ch_rst_req_i = '0;
    mx_rd_i = 1'b0; mx_block_done_i = 1'b0; mx_rst_ack_i = 1'b0; timeout_limit_i = '0;
    for (int i = 0; i < NCH; i++) wp[i] = 0;
    repeat (3) step();
    rst_i = 1'b0; clr = 1'b0;

    chk("rst_ack", 64'(mx_ack_o), 64'(0));
    chk("rst_timeout", 64'(timeout_o), 64'(0));
    chk("rst_sel", 64'(mx_sel_o), 64'(0));
    chk("rst_empty", 64'(mx_empty_o), 64'(1));
    chk("rst_rd", 64'(ch_rd_o), 64'(0));

    // Disabled ch2 must be skipped even though it holds data.
    flush();
    ch_enable_i = 4'b1011;
    load(2, 3); load(3, 3);
    wait_ack("mask", 3);
    step();
    chk("mask_select_empty", 64'(mx_empty_o), 64'(0));
    mx_rd_i = 1'b1;
    #1 chk("mask_rd_strobe", 64'(ch_rd_o), 64'(4'b1000));
    step();
    mx_rd_i = 1'b0;
    release_block();
    chk("release_idle_empty", 64'(mx_empty_o), 64'(1));
    step();
    chk("release_regrant_ack", 64'(mx_ack_o), 64'(1));
    chk("release_regrant_sel", 64'(mx_sel_o), 64'(3));
    step();
    release_block();
    chk("mask_ch2_unread", 64'(rp[2]), 64'(0));

    // Stall timeout, counter clear on read, and disabled timeout.
    flush();
    ch_enable_i = 4'hF; timeout_limit_i = 16'd5;
    load(0, 2); load(1, 2);
    wait_ack("to", 0);
    bad = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      step();
      if (j < 5) bad |= timeout_o;
      else chk("to_pulse_5th", 64'(timeout_o), 64'(1));
    end
    chk("to_early", 64'(bad), 64'(0));
    step();
    chk("to_idle_pulse", 64'({timeout_o, mx_empty_o}), 64'(2'b01));
    timeout_limit_i = 16'd3;
    step();
    chk("to_next_ack", 64'(mx_ack_o), 64'(1));
    chk("to_next_sel", 64'(mx_sel_o), 64'(1));
    for (int j = 1; j <= 6; j++) begin
      step();
      mx_rd_i = (j == 3);
      #1 chk("to_rd_clears", 64'(timeout_o), 64'(j == 6));
    end
    mx_rd_i = 1'b0;
    step();
    timeout_limit_i = '0;
    wait_ack("to_wrap", 0);
    bad = 1'b0;
    for (int j = 0; j < 30; j++) begin
      step();
      bad |= timeout_o | mx_empty_o;
    end
    chk("to_disabled", 64'(bad), 64'(0));
    release_block();

    // Done seen in IDLE is cleared by the grant and must not end the next block.
    flush();
    release_block();
    load(0, 2);
    wait_ack("hold", 0);
    bad = 1'b0;
    for (int j = 0; j < 5; j++) begin
      step();
      bad |= mx_empty_o | mx_ack_o;
    end
    chk("hold_cleared", 64'(bad), 64'(0));
    release_block();

    // Reset mid-SELECT with ptr at 2: next grant must restart from ch0.
    flush();
    ch_enable_i = 4'b0010;
    load(0, 2); load(1, 4); load(3, 2);
    wait_ack("rst_pre", 1);
    step();
    release_block();
    wait_ack("rst_wrap", 1);
    step();
    ch_enable_i = 4'hF; mx_rd_i = 1'b1; rst_i = 1'b1;
    step();
    chk("midrst_state", 64'({mx_empty_o, ch_rd_o, mx_sel_o, mx_ack_o}), 64'({1'b1, 4'b0, 2'd0, 1'b0}));
    rst_i = 1'b0; mx_rd_i = 1'b0;
    wait_ack("midrst_ptr", 0);
    step();
    release_block();

    // Reset handshake with the reader.
    flush();
    ch_enable_i = 4'hF;
    load(1, 2);
    wait_ack("hs", 1);
    step();
    ch_rst_req_i = 4'b0100;
    #1 chk("hs_req", 64'(mx_rst_req_o), 64'(1));
    ch_enable_i = 4'b1011;
    #1 chk("hs_req_masked", 64'(mx_rst_req_o), 64'(0));
    ch_enable_i = 4'hF;
    mx_rst_ack_i = 1'b1;
    #1 chk("hs_ack_bcast", 64'(ch_rst_ack_o), 64'(4'hF));
    step();
    mx_rst_ack_i = 1'b0; ch_rst_req_i = '0;
    chk("hs_idle", 64'({mx_empty_o, mx_ack_o}), 64'(2'b10));

    // Randomized blocks against the round-robin model.
    for (int it = 0; it < 8; it++) begin
      mon_en = 1'b0;
      flush();
      ch_enable_i = (it == 0) ? 4'hF : 4'($urandom);
      for (int i = 0; i < NCH; i++) begin
        load(i, (it == 0) ? 6 : int'($urandom_range(0, 6)));
        mr[i] = 0;
      end
      ptr_m = 0; nblk = 0;
      blk_q.delete();
      for (int b = 0; b < 100; b++) begin
        c_sel = -1;
        for (int i = 0; i < NCH; i++) begin
          c = (ptr_m + i) % NCH;
          if (c_sel < 0 && ch_enable_i[2'(c)] && wp[c] > mr[c]) c_sel = c;
        end
        if (c_sel < 0) break;
        blk = (it == 0) ? 3 : int'($urandom_range(1, 4));
        blk_q.push_back(blk);
        nblk++;
        x.grant = 1'b1; x.ch = CH_W'(c_sel); x.d = '0; x.t = '0; x.nw = 0;
        exp_q.push_back(x);
        for (int j = 0; j < blk && mr[c_sel] < wp[c_sel]; j++) begin
          x.grant = 1'b0;
          x.d  = mem_d[c_sel][6'(mr[c_sel])];
          x.t  = mem_t[c_sel][6'(mr[c_sel])];
          x.nw = wp[c_sel] - mr[c_sel];
          exp_q.push_back(x);
          mr[c_sel]++;
        end
        ptr_m = (c_sel + 1) % NCH;
      end
      mon_en = 1'b1;
      for (int b = 0; b < nblk; b++) begin
        ok = 1'b0;
        for (int w = 0; w < 20 && !ok; w++) begin
          step();
          ok = mx_ack_o;
        end
        chk("rand_grant_seen", 64'(ok), 64'(1));
        got = 0; ok = 1'b0;
        for (int w = 0; w < 200 && !ok; w++) begin
          step();
          if (got < blk_q[b] && !mx_empty_o) begin
            mx_rd_i = ($urandom_range(0, 2) != 0);
            if (mx_rd_i) got++;
          end else begin
            mx_rd_i = 1'b0;
            release_block();
            ok = 1'b1;
          end
        end
        chk("rand_block_done", 64'(ok), 64'(1));
      end
      repeat (6) step();
      chk("rand_drained", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
